// File: rtl/glitch_seq_mux_if.sv
// Control, trigger and configuration bus of the glitch sequencer.
// The bench drives the master side; the sequencer uses the slave side.
interface glitch_seq_mux_if #(
  parameter int N_CH  = 4,
  parameter int DLY_W = 16
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             i_trig;
  logic             i_arm;
  logic             i_abort;
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [2:0]       cfg_addr;
  logic [DLY_W-1:0] cfg_data;
  logic [N_CH-1:0]  o_out;
  logic             o_armed;
  logic             o_busy;
  logic             o_done;
  logic             o_cfg_err;

  modport master (
    output i_trig, i_arm, i_abort, cfg_we, cfg_ch, cfg_addr, cfg_data,
    input  o_out, o_armed, o_busy, o_done, o_cfg_err
  );
  modport slave (
    input  i_trig, i_arm, i_abort, cfg_we, cfg_ch, cfg_addr, cfg_data,
    output o_out, o_armed, o_busy, o_done, o_cfg_err
  );
endinterface

// File: rtl/glitch_seq_mux.sv
// Multi-channel glitch sequencer: a trigger edge starts, per channel, a
// delayed train of programmable pulses; each channel may be off, forced or inverted.
module glitch_seq_ch #(
  parameter int DLY_W = 16,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [2:0]       addr,
  input  logic [DLY_W-1:0] data,
  input  logic             go,
  input  logic             run,
  output logic             out,
  output logic             fin_nxt
);
  typedef enum logic [2:0] {S_WAIT, S_DLY, S_HIGH, S_GAP, S_FIN} ch_state_t;
  localparam logic [DLY_W-1:0] D_ONE = 1;
  localparam logic [REP_W-1:0] R_ONE = 1;

  logic [1:0]       mode;
  logic [DLY_W-1:0] dly, wid, gap, cnt, w_ld, g_ld;
  logic [REP_W-1:0] rep, rcnt;
  ch_state_t        st;
  logic             active, pulse;

  // mode[0] set = sequenced (GLITCH/INVERT); mode[1] is the idle level
  assign active  = mode[0];
  assign pulse   = ~mode[1];
  assign w_ld    = (wid == '0) ? '0 : wid - D_ONE;
  assign g_ld    = (gap == '0) ? '0 : gap - D_ONE;
  assign fin_nxt = !active ||
                   (!go && (st == S_FIN || (st == S_HIGH && cnt == '0 && rcnt == '0)));

  always_ff @(posedge clk) begin
    if (reset) begin
      mode <= '0;
      dly  <= '0;
      wid  <= '0;
      gap  <= '0;
      rep  <= '0;
      st   <= S_WAIT;
      cnt  <= '0;
      rcnt <= '0;
      out  <= 1'b0;
    end else begin
      if (wr) begin
        case (addr)
          3'd0:    mode <= data[1:0];
          3'd1:    dly  <= data;
          3'd2:    wid  <= data;
          3'd3:    gap  <= data;
          3'd4:    rep  <= REP_W'(data);
          default: ;
        endcase
      end
      out <= mode[1];
      if (!active || !run) begin
        st <= S_WAIT;
      end else if (go) begin
        rcnt <= rep;
        if (dly == '0) begin
          st  <= S_HIGH;
          cnt <= w_ld;
          out <= pulse;
        end else begin
          st  <= S_DLY;
          cnt <= dly - D_ONE;
        end
      end else begin
        case (st)
          S_DLY, S_GAP: begin
            if (cnt == '0) begin
              st  <= S_HIGH;
              cnt <= w_ld;
              out <= pulse;
            end else begin
              cnt <= cnt - D_ONE;
            end
          end
          S_HIGH: begin
            if (cnt != '0) begin
              cnt <= cnt - D_ONE;
              out <= pulse;
            end else if (rcnt == '0) begin
              st <= S_FIN;
            end else begin
              rcnt <= rcnt - R_ONE;
              st   <= S_GAP;
              cnt  <= g_ld;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

module glitch_seq_mux #(
  parameter int N_CH  = 4,
  parameter int DLY_W = 16,
  parameter int REP_W = 8
) (
  input logic             clk,
  input logic             reset,
  glitch_seq_mux_if.slave bus
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  typedef enum logic [1:0] {G_IDLE, G_ARMED, G_RUN} g_state_t;

  g_state_t        state;
  logic [2:0]      trig_sync;
  logic            trig_edge;
  logic            armed, busy, done, cfg_err;
  logic [N_CH-1:0] out, fin_nxt, wr;
  logic            go, stop, run_nxt, cfg_ok;

  // abort beats the trigger; done is only ever high in RUN when every channel has finished
  assign go      = (state == G_ARMED) && trig_edge && !bus.i_abort;
  assign stop    = bus.i_abort || done;
  assign run_nxt = go || (state == G_RUN && !stop);
  assign cfg_ok  = bus.cfg_we && (state == G_IDLE) && (bus.cfg_addr <= 3'd4);

  always_ff @(posedge clk) begin
    if (reset) begin
      trig_sync <= '0;
      trig_edge <= 1'b0;
    end else begin
      trig_sync <= {trig_sync[1:0], bus.i_trig};
      trig_edge <= trig_sync[1] & ~trig_sync[2];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= G_IDLE;
      armed   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      busy    <= run_nxt;
      done    <= run_nxt && (&fin_nxt);
      cfg_err <= bus.cfg_we && (state != G_IDLE || bus.cfg_addr > 3'd4);
      case (state)
        G_IDLE: begin
          if (bus.i_arm && !bus.i_abort) begin
            state <= G_ARMED;
            armed <= 1'b1;
          end
        end
        G_ARMED: begin
          if (bus.i_abort) begin
            state <= G_IDLE;
            armed <= 1'b0;
          end else if (trig_edge) begin
            state <= G_RUN;
            armed <= 1'b0;
          end
        end
        G_RUN: begin
          if (stop) state <= G_IDLE;
        end
        default: state <= G_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign wr[i] = cfg_ok && (bus.cfg_ch == CH_W'(i));
    glitch_seq_ch #(.DLY_W(DLY_W), .REP_W(REP_W)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr[i]),
      .addr    (bus.cfg_addr),
      .data    (bus.cfg_data),
      .go      (go),
      .run     (run_nxt),
      .out     (out[i]),
      .fin_nxt (fin_nxt[i])
    );
  end

  assign bus.o_out     = out;
  assign bus.o_armed   = armed;
  assign bus.o_busy    = busy;
  assign bus.o_done    = done;
  assign bus.o_cfg_err = cfg_err;
endmodule

// File: tb/tb_glitch_seq_mux.sv
// Bench for glitch_seq_mux: directed and random scenarios checked every cycle
// against a timing model built from delay/width/gap/repeat arithmetic.
module tb_glitch_seq_mux;
  localparam int N_CH  = 4;
  localparam int DLY_W = 16;
  localparam int REP_W = 8;
  localparam int BIG   = 1 << 28;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  glitch_seq_mux_if #(.N_CH(N_CH), .DLY_W(DLY_W)) bus ();
  glitch_seq_mux #(.N_CH(N_CH), .DLY_W(DLY_W), .REP_W(REP_W)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0, n_fail = 0, cur_t = -1;
  int m_mode[N_CH], m_dly[N_CH], m_wid[N_CH], m_gap[N_CH], m_rep[N_CH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, cur_t, got, exp);
    end
  endtask

  function automatic int wcl(int i); return (m_wid[i] == 0) ? 1 : m_wid[i]; endfunction
  function automatic int gcl(int i); return (m_gap[i] == 0) ? 1 : m_gap[i]; endfunction

  function automatic int max_span();
    int s = 0;
    for (int i = 0; i < N_CH; i++)
      if (m_mode[i] % 2 == 1) begin
        int sp = m_dly[i] + (m_rep[i] + 1) * wcl(i) + m_rep[i] * gcl(i);
        if (sp > s) s = sp;
      end
    return s;
  endfunction

  // tr: cycles since the channel's first active cycle
  function automatic bit pulse_at(int i, int tr);
    int p = wcl(i) + gcl(i);
    if (tr < 0) return 1'b0;
    return (tr / p <= m_rep[i]) && (tr % p < wcl(i));
  endfunction

  task automatic cfg_wr(input int ch, input int addr, input int data);
    @(posedge clk); #1;
    bus.cfg_we = 1'b1; bus.cfg_ch = 2'(ch); bus.cfg_addr = 3'(addr); bus.cfg_data = 16'(data);
    case (addr)
      0: m_mode[ch] = data & 3;
      1: m_dly[ch]  = data & 16'hffff;
      2: m_wid[ch]  = data & 16'hffff;
      3: m_gap[ch]  = data & 16'hffff;
      4: m_rep[ch]  = data & 8'hff;
      default: ;
    endcase
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    @(negedge clk);
    cur_t = -1;
    chk("cfg_err_idle", 32'(bus.o_cfg_err), 32'(addr > 4));
  endtask

  task automatic set_ch(input int ch, input int md, input int dl, input int wd, input int gp, input int rp);
    cfg_wr(ch, 0, md); cfg_wr(ch, 1, dl); cfg_wr(ch, 2, wd); cfg_wr(ch, 3, gp); cfg_wr(ch, 4, rp);
  endtask

  // all times relative to the arm cycle t=0; -1 disables an event; len 0 = auto
  task automatic run_scn(input bit do_arm, input int trig_at, input bit glitch, input int abort_at,
                         input int retrig_at, input int cfgw_at, input int len);
    int a, e, d, run_end, last, armed_end;
    bit run;
    logic [N_CH-1:0] eo;
    a   = (abort_at < 0) ? BIG : abort_at;
    e   = (trig_at < 0 || glitch) ? BIG : trig_at + 3;
    run = do_arm && e < a;
    d   = run ? e + 1 + max_span() : BIG;
    run_end   = (d < a) ? d : a;
    armed_end = run ? e : a;
    last = run ? run_end : ((a < BIG) ? a : e);
    if (len == 0) len = last + 4;
    if (retrig_at + 4 > len) len = retrig_at + 4;
    for (int t = 0; t < len; t++) begin
      @(posedge clk); #1;
      cur_t = t;
      bus.i_arm    = do_arm && t == 0;
      bus.i_abort  = (t == abort_at);
      bus.i_trig   = (!glitch && trig_at >= 0 && t >= trig_at && t < trig_at + 2) || (t == retrig_at);
      bus.cfg_we   = (t == cfgw_at);
      bus.cfg_ch   = '0;
      bus.cfg_addr = 3'd1;
      bus.cfg_data = 16'h00ff;
      if (glitch && t == trig_at) begin
        bus.i_trig = 1'b1; #2; bus.i_trig = 1'b0;
      end
      @(negedge clk);
      for (int i = 0; i < N_CH; i++) begin
        bit idle, on;
        idle = (m_mode[i] >= 2);
        on = 1'b0;
        if (run && m_mode[i] % 2 == 1 && t >= e + 1 && t <= run_end)
          on = pulse_at(i, t - (e + 1 + m_dly[i]));
        eo[i] = on ? !idle : idle;
      end
      chk("out",     32'(bus.o_out),     32'(eo));
      chk("armed",   32'(bus.o_armed),   32'(do_arm && t >= 1 && t <= armed_end));
      chk("busy",    32'(bus.o_busy),    32'(run && t >= e + 1 && t <= run_end));
      chk("done",    32'(bus.o_done),    32'(run && t == d && d <= a));
      chk("cfg_err", 32'(bus.o_cfg_err), 32'(cfgw_at >= 0 && t == cfgw_at + 1));
    end
    @(posedge clk); #1;
    bus.i_arm = 1'b0; bus.i_abort = 1'b0; bus.i_trig = 1'b0; bus.cfg_we = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    @(negedge clk);
    cur_t = -1;
    chk({tag, "_out"}, 32'(bus.o_out), 32'd0);
    chk({tag, "_flags"}, 32'({bus.o_armed, bus.o_busy, bus.o_done, bus.o_cfg_err}), 32'd0);
  endtask

  task automatic clr_model();
    for (int i = 0; i < N_CH; i++) begin
      m_mode[i] = 0; m_dly[i] = 0; m_wid[i] = 0; m_gap[i] = 0; m_rep[i] = 0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0d", cur_t);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_trig = 1'b0; bus.i_arm = 1'b0; bus.i_abort = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_addr = '0; bus.cfg_data = '0;
    clr_model();
    repeat (3) @(posedge clk);
    chk_zero("in_reset");
    @(posedge clk); #1; reset = 1'b0;
    chk_zero("after_reset");

    // all channels OFF: done one cycle after the edge, outputs stay 0
    run_scn(1, 1, 0, -1, -1, -1, 0);

    set_ch(0, 1, 5, 3, 0, 0);
    run_scn(1, 2, 0, -1, -1, -1, 0);

    set_ch(0, 0, 0, 0, 0, 0);
    set_ch(1, 3, 0, 2, 4, 2);
    set_ch(2, 2, 0, 0, 0, 0);
    run_scn(1, 1, 0, -1, -1, -1, 0);

    set_ch(0, 1, 2, 10, 0, 0);
    set_ch(1, 1, 20, 1, 0, 0);
    run_scn(1, 1, 0, 9, -1, -1, 0);        // abort at E+5

    cfg_wr(2, 5, 3);                       // bad address in IDLE
    cfg_wr(1, 0, 0);
    set_ch(0, 1, 5, 3, 0, 0);
    run_scn(1, 3, 0, -1, 8, 2, 0);         // dropped write in ARMED, retrigger in RUN

    run_scn(1, 2, 1, 12, -1, -1, 15);      // sub-cycle glitch never arms a run
    run_scn(0, 1, 0, -1, -1, -1, 10);      // trigger in IDLE

    set_ch(0, 1, 1, 0, 0, 2);              // width 0 and gap 0 act as 1
    run_scn(1, 2, 0, -1, -1, -1, 0);

    set_ch(0, 1, 2, 10, 0, 0);
    run_scn(1, 1, 0, -1, -1, -1, 7);       // stop mid-sequence, then reset
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    chk_zero("mid_reset");
    clr_model();
    run_scn(1, 1, 0, -1, -1, -1, 0);

    for (int n = 0; n < 20; n++) begin
      int ta, ea, aa, rt, cw;
      for (int i = 0; i < N_CH; i++)
        set_ch(i, $urandom_range(0, 7), $urandom_range(0, 6), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 2) | ($urandom_range(0, 1) << 8));
      ta = $urandom_range(1, 4);
      ea = ta + 3;
      aa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, ea + max_span() + 2) : -1;
      rt = ($urandom_range(0, 2) == 0) ? ea + 1 + $urandom_range(0, 3) : -1;
      cw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, ea) : -1;
      if (aa >= 0 && cw > aa) cw = -1;
      run_scn(1, ta, 0, aa, rt, cw, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
